div_ctrl: RTL
=============

Name: div_ctrl

Overview:
- Multi-cycle DIV/DIVU sequencer for the execute stage; owns a radix-2 restoring divider datapath and its control FSM.
- Holds the pipeline through stall_o while iterating.
- Returns quotient (for LO) and remainder (for HI) to ex, which drives whilo_o/hi_o/lo_o.
- Honours pipeline annul (flush/exception) at any cycle.

Parameters:
- DATA_W, 32, operand/result width; iteration count equals DATA_W.
- CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > DATA_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; asynchronous, active-high (`ENABLE).
- start_i  input  1  ex presents OP_DIV/OP_DIVU; held high until ready_o is seen.
- signed_i  input  1  1 = DIV (two's complement), 0 = DIVU.
- dividend_i  input  DATA_W  reg1 operand.
- divisor_i  input  DATA_W  reg2 operand.
- annul_i  input  1  flush; abort any operation.
- stall_o  output  1  stall request to pipeline control.
- ready_o  output  1  result valid.
- quotient_o  output  DATA_W  quotient, destined for LO.
- remainder_o  output  DATA_W  remainder, destined for HI.

Behaviour:
- Reset (async, immediate):
  - state = IDLE; counter = 0.
  - ready_o = 0; quotient_o = 0; remainder_o = 0.
  - stall_o = 0 while rst is high.
- FSM states: IDLE, DIVZERO, ON, END.
- IDLE:
  - start_i=1 and annul_i=0 at edge T: operands are latched.
  - Signed mode: absolute values are latched, along with sign flags q_neg = sign(dividend) XOR sign(divisor) and r_neg = sign(dividend).
  - divisor == 0: next state DIVZERO.
  - Otherwise: next state ON with counter = 0 and partial remainder = 0.
- DIVZERO: one cycle, then END with quotient = 0 and remainder = 0 (decided result for divide-by-zero).
- ON, one restoring step per cycle:
  - Shift {rem, dividend} left 1.
  - Trial-subtract the divisor.
  - Set the quotient bit if the result is non-negative, keeping the difference; otherwise restore.
  - counter increments each cycle.
  - After the DATA_W-th step (counter == DATA_W-1 at the edge), go to END.
- END:
  - Signed fix-up: quotient negated if q_neg; remainder negated if r_neg. Fix-up is applied to the registered outputs on the ON->END (or DIVZERO->END) edge.
  - ready_o = 1 and the outputs hold stable while start_i stays high.
  - Return to IDLE on the first cycle start_i = 0. ready_o and outputs clear to 0 on that transition.
- Latency: start accepted at edge T gives ready_o high from T+DATA_W+1 (T+33 for 32-bit). Divide-by-zero gives ready_o at T+2.
- stall_o (combinational):
  - 1 when (IDLE and start_i and !annul_i), DIVZERO, or ON.
  - 0 in END and in IDLE without a request.
  - ex therefore advances on the END cycle.
- annul_i (any state): next state IDLE, ready_o = 0, outputs cleared. annul_i has priority over start_i in the same cycle, and stall_o is forced to 0 that cycle.
- Back-to-back: a new divide is accepted only from IDLE, so at least one idle cycle separates operations (start_i must drop).
- Edge case: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0 (wraps, no trap).
- No internal forwarding: ex resolves operand hazards before asserting start_i.

Decomposition:
- Additions to cpu_defines package:
  - Div_state_t enum {DIV_IDLE, DIV_ZERO, DIV_ON, DIV_END}.
  - Constants DIV_CYCLES = 32, DIV_CNT_W = 6.
  - Oper_t entries OP_DIV and OP_DIVU, if not present.
- Sub-module div_step (combinational):
  - Inputs: partial remainder, dividend, divisor.
  - Outputs: next remainder, next dividend with the quotient bit shifted in.
- The FSM, counter, sign handling and output registers stay in div_ctrl.

Test Plan:
- DIVU 100 / 7: start at edge T. stall_o is high T..T+32 and ready_o rises at T+33 with quotient 0x0000000E, remainder 0x00000002. start_i dropped at T+34 sends the block to IDLE and clears ready_o.
- DIV -7 / 2 (0xFFFFFFF9 / 0x2): quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. DIV 7 / -2 gives quotient 0xFFFFFFFD, remainder 0x00000001.
- DIVU 5 / 0: ready_o at T+2 with quotient 0, remainder 0; stall_o high for exactly 2 cycles.
- Annul at iteration 10: ON with counter = 10 and annul_i = 1 gives IDLE next cycle, stall_o 0, ready_o never asserted. A new start_i then gives a full 33-cycle operation with a correct result (0xFFFFFFFF / 0x10 unsigned gives 0x0FFFFFFF rem 0xF).
- Reset mid-operation: rst pulsed asynchronously between edges during ON. All outputs go 0 immediately and the state is IDLE. After release, DIV 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0.
- start_i with annul_i in the same IDLE cycle: no operation is started and stall_o stays 0.

Source files
------------

// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the multi-cycle divide sequencer.
package div_ctrl_pkg;

   // Divider sequencer states
   typedef enum logic [1:0] {
      DIV_IDLE,
      DIV_ZERO,
      DIV_ON,
      DIV_END
   } div_state_t;

   // Iteration count and matching counter width
   localparam int DIV_CYCLES = 32;
   localparam int DIV_CNT_W  = 6;

   // Execute-stage operations relevant to the HI/LO unit
   typedef enum logic [3:0] {
      OP_NOP,
      OP_MULT,
      OP_MULTU,
      OP_DIV,
      OP_DIVU,
      OP_MTHI,
      OP_MTLO
   } oper_t;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift {rem, dvd} left, trial-subtract
// the divisor, and shift the resulting quotient bit into the dividend.
module div_step #(
   parameter int W = 32
) (
   input  logic [W-1:0] rem_i,
   input  logic [W-1:0] dvd_i,
   input  logic [W-1:0] dsr_i,
   output logic [W-1:0] rem_o,
   output logic [W-1:0] dvd_o
);

   logic [W:0] shifted;
   logic [W:0] diff;
   logic       ge;

   // Trial subtraction; the partial remainder is always below the divisor,
   // so the kept value fits in W bits.
   always_comb begin
      shifted = {rem_i, dvd_i[W-1]};
      diff    = shifted - {1'b0, dsr_i};
      ge      = (shifted >= {1'b0, dsr_i});
      rem_o   = ge ? diff[W-1:0] : shifted[W-1:0];
      dvd_o   = {dvd_i[W-2:0], ge};
   end

endmodule

// File: rtl/div_ctrl.sv
// DIV/DIVU sequencer: latches operands, iterates a restoring divider for
// DATA_W cycles while stalling the pipeline, then presents quotient (LO)
// and remainder (HI) until ex drops its request.
module div_ctrl
   import div_ctrl_pkg::*;
#(
   parameter int DATA_W = DIV_CYCLES,
   parameter int CNT_W  = DIV_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic              signed_i,
   input  logic [DATA_W-1:0] dividend_i,
   input  logic [DATA_W-1:0] divisor_i,
   input  logic              annul_i,
   output logic              stall_o,
   output logic              ready_o,
   output logic [DATA_W-1:0] quotient_o,
   output logic [DATA_W-1:0] remainder_o
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

   div_state_t        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] rem_q, rem_d;
   logic [DATA_W-1:0] dvd_q, dvd_d;
   logic [DATA_W-1:0] dsr_q, dsr_d;
   logic              q_neg_q, q_neg_d;
   logic              r_neg_q, r_neg_d;
   logic [DATA_W-1:0] quot_q, quot_d;
   logic [DATA_W-1:0] remo_q, remo_d;
   logic              ready_q, ready_d;

   logic [DATA_W-1:0] step_rem;
   logic [DATA_W-1:0] step_dvd;

   div_step #(.W(DATA_W)) u_step (
      .rem_i (rem_q),
      .dvd_i (dvd_q),
      .dsr_i (dsr_q),
      .rem_o (step_rem),
      .dvd_o (step_dvd)
   );

   // State and datapath registers; reset clears everything immediately
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= DIV_IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         dvd_q   <= '0;
         dsr_q   <= '0;
         q_neg_q <= 1'b0;
         r_neg_q <= 1'b0;
         quot_q  <= '0;
         remo_q  <= '0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         dvd_q   <= dvd_d;
         dsr_q   <= dsr_d;
         q_neg_q <= q_neg_d;
         r_neg_q <= r_neg_d;
         quot_q  <= quot_d;
         remo_q  <= remo_d;
         ready_q <= ready_d;
      end
   end

   // Next-state logic, operand capture, iteration and sign fix-up
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      dvd_d   = dvd_q;
      dsr_d   = dsr_q;
      q_neg_d = q_neg_q;
      r_neg_d = r_neg_q;
      quot_d  = quot_q;
      remo_d  = remo_q;
      ready_d = ready_q;

      case (state_q)
         DIV_IDLE: begin
            if (start_i) begin
               // Signed operands are reduced to magnitudes; the signs are
               // reapplied once the unsigned result is known.
               if (signed_i) begin
                  dvd_d   = dividend_i[DATA_W-1] ? (~dividend_i + 1'b1) : dividend_i;
                  dsr_d   = divisor_i[DATA_W-1]  ? (~divisor_i  + 1'b1) : divisor_i;
                  q_neg_d = dividend_i[DATA_W-1] ^ divisor_i[DATA_W-1];
                  r_neg_d = dividend_i[DATA_W-1];
               end else begin
                  dvd_d   = dividend_i;
                  dsr_d   = divisor_i;
                  q_neg_d = 1'b0;
                  r_neg_d = 1'b0;
               end
               rem_d   = '0;
               cnt_d   = '0;
               state_d = (divisor_i == '0) ? DIV_ZERO : DIV_ON;
            end
         end
         DIV_ZERO: begin
            // Divide-by-zero yields a defined all-zero result
            quot_d  = '0;
            remo_d  = '0;
            ready_d = 1'b1;
            state_d = DIV_END;
         end
         DIV_ON: begin
            rem_d = step_rem;
            dvd_d = step_dvd;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_CNT) begin
               quot_d  = q_neg_q ? (~step_dvd + 1'b1) : step_dvd;
               remo_d  = r_neg_q ? (~step_rem + 1'b1) : step_rem;
               ready_d = 1'b1;
               state_d = DIV_END;
            end
         end
         DIV_END: begin
            // Hold the result until ex withdraws its request
            if (!start_i) begin
               quot_d  = '0;
               remo_d  = '0;
               ready_d = 1'b0;
               state_d = DIV_IDLE;
            end
         end
         default: begin
            state_d = DIV_IDLE;
         end
      endcase

      // A flush wins over everything, including a same-cycle request
      if (annul_i) begin
         state_d = DIV_IDLE;
         cnt_d   = '0;
         quot_d  = '0;
         remo_d  = '0;
         ready_d = 1'b0;
      end
   end

   // Stall while a divide is being requested or is in progress
   always_comb begin
      stall_o = 1'b0;
      if (!rst && !annul_i) begin
         case (state_q)
            DIV_IDLE: stall_o = start_i;
            DIV_ZERO: stall_o = 1'b1;
            DIV_ON:   stall_o = 1'b1;
            default:  stall_o = 1'b0;
         endcase
      end
   end

   assign ready_o     = ready_q;
   assign quotient_o  = quot_q;
   assign remainder_o = remo_q;

endmodule
